// File: rtl/dma_ctrl.sv
// Atari ST floppy-path DMA controller: register window, fdc pass-through, address/count FSM.
// Optional macro DMA_ACSI_EN routes index-0 pass-through to acsi_sel when mode[3] is set.
module dma_ctrl #(
  parameter int unsigned SECTOR_BYTES = 512
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        cpu_sel,
  input  logic [2:0]  cpu_addr,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic        fdc_sel,
  output logic [1:0]  fdc_addr,
  output logic        fdc_rw,
  output logic [7:0]  fdc_din,
  input  logic [7:0]  fdc_dout,
  input  logic        fdc_drq,
  output logic        dma_ack,
  input  logic        io_sector_done,
  input  logic        io_last,
  input  logic [2:0]  io_status_sel,
  output logic [7:0]  io_status_byte,
  output logic        acsi_sel
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_ACK
  } state_t;

  localparam logic [23:0] LP_INC = 24'(SECTOR_BYTES);

  state_t      r_state, w_state_nxt;
  logic [8:0]  r_mode, w_mode_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt, w_cnt_dec;
  logic [23:0] r_addr, w_addr_nxt;
  logic        r_err_n, w_err_nxt;
  logic        r_last, w_last_nxt;

  logic w_wr, w_wr_cnt, w_wr_mode, w_dir_flip;
  logic w_wr_hi, w_wr_mid, w_wr_lo, w_wr_addr;
  logic w_pass, w_acsi_route, w_cnt_nz, w_busy, w_rd;
  logic w_unused;

  assign w_wr       = clk_en && cpu_sel && !cpu_rw;
  assign w_wr_cnt   = w_wr && (cpu_addr == 3'd0) && r_mode[4];
  assign w_wr_mode  = w_wr && (cpu_addr == 3'd1);
  assign w_dir_flip = w_wr_mode && (cpu_din[8] != r_mode[8]);
  assign w_wr_hi    = w_wr && (cpu_addr == 3'd2);
  assign w_wr_mid   = w_wr && (cpu_addr == 3'd3);
  assign w_wr_lo    = w_wr && (cpu_addr == 3'd4);
  assign w_wr_addr  = w_wr_hi || w_wr_mid || w_wr_lo;
  assign w_rd       = cpu_sel && cpu_rw;
  assign w_cnt_nz   = (r_cnt != '0);
  assign w_busy     = (r_state != S_IDLE);

`ifdef DMA_ACSI_EN
  assign w_acsi_route = r_mode[3];
`else
  assign w_acsi_route = 1'b0;
`endif

  assign w_pass   = cpu_sel && (cpu_addr == 3'd0) && !r_mode[4];
  assign fdc_sel  = w_pass && !w_acsi_route;
  assign acsi_sel = w_pass && w_acsi_route;
  assign fdc_addr = r_mode[2:1];
  assign fdc_rw   = cpu_rw;
  assign fdc_din  = cpu_din[7:0];

  assign w_unused = ^{cpu_din[15:9], r_mode[7:5], r_mode[0]};

  // CPU writes are applied after the STEP update so they take precedence.
  always_comb begin
    w_cnt_dec = w_cnt_nz ? (r_cnt - 8'd1) : '0;

    w_cnt_nxt = r_cnt;
    if (r_state == S_STEP) w_cnt_nxt = w_cnt_dec;
    if (w_wr_cnt)          w_cnt_nxt = cpu_din[7:0];
    if (w_dir_flip)        w_cnt_nxt = '0;

    w_addr_nxt = r_addr;
    if ((r_state == S_STEP) && !w_wr_addr) w_addr_nxt = r_addr + LP_INC;
    if (w_wr_hi)  w_addr_nxt[23:16] = cpu_din[7:0];
    if (w_wr_mid) w_addr_nxt[15:8]  = cpu_din[7:0];
    if (w_wr_lo)  w_addr_nxt[7:0]   = cpu_din[7:0];
    w_addr_nxt[0] = 1'b0;

    w_err_nxt = r_err_n;
    if ((r_state == S_IDLE) && io_sector_done && !w_cnt_nz) w_err_nxt = 1'b0;
    if (w_dir_flip) w_err_nxt = 1'b1;

    w_mode_nxt = w_wr_mode ? cpu_din[8:0] : r_mode;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    dma_ack     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_sector_done && w_cnt_nz) begin
          w_state_nxt = S_STEP;
          w_last_nxt  = io_last;
        end
      end
      S_STEP: begin
        w_state_nxt = (r_last || (w_cnt_nxt == '0)) ? S_ACK : S_IDLE;
      end
      S_ACK: begin
        dma_ack     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode  <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_err_n <= 1'b1;
    end else begin
      r_mode  <= w_mode_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_err_n <= w_err_nxt;
    end
  end

  always_comb begin
    cpu_dout = '0;
    if (w_rd) begin
      case (cpu_addr)
        3'd0:    if (!r_mode[4] && !w_acsi_route) cpu_dout = {8'h00, fdc_dout};
        3'd1:    cpu_dout = {13'b0, fdc_drq, w_cnt_nz, r_err_n};
        3'd2:    cpu_dout = {8'h00, r_addr[23:16]};
        3'd3:    cpu_dout = {8'h00, r_addr[15:8]};
        3'd4:    cpu_dout = {8'h00, r_addr[7:0]};
        default: cpu_dout = '0;
      endcase
    end
  end

  always_comb begin
    io_status_byte = '0;
    case (io_status_sel)
      3'd0:    io_status_byte = r_addr[23:16];
      3'd1:    io_status_byte = r_addr[15:8];
      3'd2:    io_status_byte = r_addr[7:0];
      3'd3:    io_status_byte = r_cnt;
      3'd4:    io_status_byte = {r_mode[8], r_mode[3], 3'b000, w_busy, w_cnt_nz, r_err_n};
      default: io_status_byte = '0;
    endcase
  end

endmodule

// File: doc/dma_ctrl.md
# dma_ctrl

Atari ST DMA controller for the floppy path. It sits between the 68000 bus and the `fdc` block. It decodes the DMA register window and forwards disk-controller accesses to `fdc`. It holds the 24-bit DMA address counter, sector count and mode registers, and converts per-sector completion pulses from the IO controller into the single-cycle `dma_ack` that `fdc` consumes.

## Interface
Parameters:
- `SECTOR_BYTES`, default 512: address increment applied per completed sector.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clk_en`  in  1  CPU bus enable qualifying register writes.
- `cpu_sel`  in  1  DMA register window selected.
- `cpu_addr`  in  3  register index: 0 = disk data / sector count, 1 = mode (write) / status (read), 2/3/4 = address hi/mid/lo.
- `cpu_rw`  in  1  1 = read.
- `cpu_din`  in  16  write data.
- `cpu_dout`  out  16  read data; 0 when not reading.
- `fdc_sel`  out  1  `fdc` chip select.
- `fdc_addr`  out  2  `fdc` register address.
- `fdc_rw`  out  1  `fdc` read/write.
- `fdc_din`  out  8  data to `fdc`.
- `fdc_dout`  in  8  data from `fdc`.
- `fdc_drq`  in  1  `fdc` data request, used for status.
- `dma_ack`  out  1  one-cycle acknowledge to `fdc`.
- `io_sector_done`  in  1  IO controller finished one sector (pulse).
- `io_last`  in  1  qualifies `io_sector_done`: this is the final sector of the command.
- `io_status_sel`  in  3  IO-side status index.
- `io_status_byte`  out  8  IO-side status.
- `acsi_sel`  out  1  ACSI chip select (see Configuration).

## Operation
- Mode register `mode[8:0]`:
  - bit8 = direction (1 = write to disk).
  - bit4 = sector-count select.
  - bit3 = ACSI select.
  - bits2:1 = `fdc_addr`.
- Index 0 access with `mode[4]`=0: pass-through to `fdc`.
  - `fdc_sel` = `cpu_sel`, `fdc_rw` = `cpu_rw`, `fdc_din` = `cpu_din[7:0]`.
  - Reads return {8'h00, `fdc_dout`}.
- Index 0 access with `mode[4]`=1:
  - Write loads sector count `cnt[7:0]`; `fdc_sel`=0.
  - Reads return 16'h0000 (count is write-only).
- Writes to index 1: a write whose bit8 differs from the current `mode[8]` clears `cnt` to 0 and sets `err_n` to 1, then loads `mode`.
- Index 1 read returns {13'b0, `fdc_drq`, `cnt`!=0, `err_n`}.
- Address counter `addr[23:0]`: indices 2/3/4 write/read bytes [23:16]/[15:8]/[7:0]. `addr[0]` is forced 0.
- FSM states:
  - IDLE: on `io_sector_done`, if `cnt`==0 set `err_n`=0 and stay in IDLE; otherwise go to STEP.
  - STEP: `addr` += SECTOR_BYTES, `cnt` -= 1. Go to ACK if `io_last` was latched or the new `cnt`==0; otherwise go to IDLE.
  - ACK: `dma_ack`=1 for one cycle, then IDLE.
- `io_status_byte` by `io_status_sel`:
  - 0 = `addr[23:16]`, 1 = `addr[15:8]`, 2 = `addr[7:0]`, 3 = `cnt`.
  - 4 = {`mode[8]`, `mode[3]`, 3'b0, state!=IDLE, `cnt`!=0, `err_n`}.
  - Others = 0.
- Arithmetic: `addr` wraps modulo 2^24. `cnt` never decrements below 0.

## Timing
- Reset values: `mode`=0, `cnt`=0, `addr`=0, `err_n`=1, state IDLE, `dma_ack`=0, `cpu_dout`=0, `acsi_sel`=0. Pass-through outputs follow their inputs combinationally.
- Register writes take effect on the clock edge where `clk_en && cpu_sel && !cpu_rw`.
- Reads are combinational.
- `io_last` is sampled in the same cycle as `io_sector_done`.
- Latency from `io_sector_done` to `dma_ack` is exactly 2 cycles (IDLE→STEP→ACK).
- `io_sector_done` arriving outside IDLE is ignored.
- A CPU write to `addr` or `cnt` in the STEP cycle wins over the STEP update.
- A direction toggle in the STEP cycle wins: `cnt` ends at 0. The FSM still proceeds to ACK.
- Reset asserted mid-transfer returns to reset values immediately. No `dma_ack` is emitted.

## Configuration
- `DMA_ACSI_EN` defined:
  - Index 0 pass-through with `mode[3]`=1 drives `acsi_sel` instead of `fdc_sel`.
  - Reads then return 16'h0000.
- `DMA_ACSI_EN` undefined:
  - `mode[3]` is stored and reported but ignored for routing.
  - `acsi_sel` is tied to 0.
  - All pass-through accesses go to `fdc`.

## Test plan
- Reset → `io_status_byte`(sel 4)=8'h01. Index 1 read = 16'h0001.
- Write mode 16'h0090, `cnt`=2, `addr`=24'h07FFF0, then two `io_sector_done` pulses with `io_last`=0 → `addr`=24'h0803F0, `cnt`=0, one `dma_ack` exactly 2 cycles after the second pulse.
- `cnt`=0, pulse `io_sector_done` → status bit0 reads 0, no `dma_ack`. Toggling mode bit8 restores bit0=1.
- Mode 16'h0004, write index 0 = 16'h0055 → `fdc_sel`=1, `fdc_addr`=2, `fdc_din`=8'h55. Read returns {8'h00, `fdc_dout`}.
- `cnt`=5, pulse with `io_last`=1 → `cnt`=4, `dma_ack` asserted once. `addr`=24'hFFFE00 with `cnt`=1 → wraps to 24'h000000.
- With `DMA_ACSI_EN`, mode 16'h0008, index 0 access → `acsi_sel`=1, `fdc_sel`=0. Without the macro → `fdc_sel`=1.
